// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timebase and BCD time counter.
// Optional lap hold is enabled in the top by defining STOPWATCH_LAP_HOLD_EN.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [3:0] DP_SEL = 4'b0100;

  localparam bcd_t MAX_HUND  = 4'd9;
  localparam bcd_t MAX_TENTH = 4'd9;
  localparam bcd_t MAX_SEC_U = 4'd9;
  localparam bcd_t MAX_SEC_T = 4'd5;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit that wraps at MAX and reports carry combinationally.
// Chained through carry to build the SS.hh time value.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  logic w_at_max;

  // >= keeps the digit inside BCD range even if it were ever disturbed
  assign w_at_max = (q >= MAX);
  assign carry    = inc && w_at_max;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= w_at_max ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch timebase: prescaler, run/pause FSM and 4-digit BCD SS.hh counter.
// Define STOPWATCH_LAP_HOLD_EN to add the lap hold (frozen display, live count).
//
// state    | meaning
// ST_IDLE  | time zero, stopped
// ST_RUN   | prescaler and digits counting
// ST_PAUSE | stopped, time and partial prescaler period held
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] digits,
  output logic        running,
  output logic        tick,
  output logic        rollover,
  output logic [3:0]  dp_sel
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [PW-1:0] TC = PW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("stopwatch_bcd_counter: CLK_HZ/TICK_HZ must be at least 2");
  end

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_rollover;
  logic          w_tick;
  logic          w_c0, w_c1, w_c2, w_c3;
  bcd_t          w_hund, w_tenth, w_sec_u, w_sec_t;
  logic [15:0]   w_live;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start_stop) w_state_nxt = ST_RUN;
      ST_RUN:   if (start_stop) w_state_nxt = ST_PAUSE;
      ST_PAUSE: begin
        if (start_stop)  w_state_nxt = ST_RUN;
        else if (clear)  w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // clear beats a terminal count: the period restarts and nothing increments
  assign w_tick = (r_state == ST_RUN) && (r_presc == TC) && !clear;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_tick     <= 1'b0;
      r_rollover <= 1'b0;
    end else begin
      r_tick     <= w_tick;
      r_rollover <= w_c3;
      if (clear) begin
        r_presc <= '0;
      end else if (r_state == ST_RUN) begin
        r_presc <= (r_presc == TC) ? '0 : r_presc + 1'b1;
      end
    end
  end

  bcd_digit_counter #(.MAX(MAX_HUND)) u_hund (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(w_tick), .q(w_hund), .carry(w_c0)
  );
  bcd_digit_counter #(.MAX(MAX_TENTH)) u_tenth (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(w_c0), .q(w_tenth), .carry(w_c1)
  );
  bcd_digit_counter #(.MAX(MAX_SEC_U)) u_sec_u (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(w_c1), .q(w_sec_u), .carry(w_c2)
  );
  bcd_digit_counter #(.MAX(MAX_SEC_T)) u_sec_t (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(w_c2), .q(w_sec_t), .carry(w_c3)
  );

  assign w_live = {w_sec_t, w_sec_u, w_tenth, w_hund};

`ifdef STOPWATCH_LAP_HOLD_EN
  logic        r_hold;
  logic [15:0] r_hold_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold     <= 1'b0;
      r_hold_val <= '0;
    end else if (clear) begin
      r_hold <= 1'b0;
    end else if (lap && (r_state == ST_RUN)) begin
      if (r_hold) begin
        r_hold <= 1'b0;
      end else begin
        r_hold     <= 1'b1;
        r_hold_val <= w_live;
      end
    end
  end

  assign digits = r_hold ? r_hold_val : w_live;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign digits       = w_live;
`endif

  assign running  = (r_state == ST_RUN);
  assign tick     = r_tick;
  assign rollover = r_rollover;
  assign dp_sel   = DP_SEL;

endmodule

// File: doc/stopwatch_bcd_counter.md
Name: stopwatch_bcd_counter

Overview:
- Timebase and 4-digit BCD time counter for the stopwatch, format SS.hh, range 00.00–59.99.
- Sits directly upstream of the per-digit hex-to-7-segment decoder and display scan logic; supplies one 4-bit BCD nibble per digit plus status.
- Start/stop and clear come from already-debounced single-cycle button pulses.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz (1/100 s resolution).
- DIV (localparam), CLK_HZ/TICK_HZ, prescaler terminal count. Integer division; elaboration error if DIV < 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- start_stop  in  1  one-cycle pulse; toggles run/pause
- clear  in  1  one-cycle pulse; zeroes time
- lap  in  1  one-cycle pulse; used only with LAP_HOLD_EN, ignored otherwise
- digits  out  16  BCD: [3:0] hundredths, [7:4] tenths, [11:8] seconds units, [15:12] seconds tens
- running  out  1  high in RUN
- tick  out  1  one-cycle pulse on each count increment
- rollover  out  1  one-cycle pulse when 59.99 wraps to 00.00
- dp_sel  out  4  constant 4'b0100; decimal point after seconds units

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, digits=0, prescaler=0, running=0, tick=0, rollover=0, lap hold cleared. rst_n has priority over every other input in that cycle.
- States:
  - IDLE: time zero, stopped.
  - RUN: counting.
  - PAUSE: stopped, nonzero or zero time held.
- Transitions:
  - IDLE + start_stop -> RUN.
  - RUN + start_stop -> PAUSE.
  - PAUSE + start_stop -> RUN.
  - PAUSE + clear -> IDLE.
  - RUN + clear -> stay RUN; digits=0, prescaler=0.
  - IDLE + clear -> no change.
- Prescaler: increments only in RUN. At DIV-1 it wraps to 0 and asserts tick for that cycle. In PAUSE it holds its value, so a resumed count keeps the partial period.
- Digit chain on tick, all digits updated in the same cycle, registered outputs:
  - hundredths 0–9, carries to tenths.
  - tenths 0–9, carries to seconds units.
  - seconds units 0–9, carries to seconds tens.
  - seconds tens 0–5.
  - 59.99 + tick -> 00.00 with rollover=1 that cycle; state stays RUN.
- Latency: digits change on the clk edge at which tick is high; the digits value is valid in the same cycle tick is observed.
- Simultaneous events:
  - clear and terminal count in the same cycle: clear wins; no tick, no rollover, digits=0.
  - start_stop and clear together in PAUSE: -> RUN with digits=0.
  - start_stop and clear together in RUN: -> PAUSE with digits=0, prescaler=0. The next cycle is PAUSE, not IDLE; a further clear moves it to IDLE.
  - start_stop in RUN on a terminal-count cycle: the tick and increment still occur, then state -> PAUSE.
- Digits never hold non-BCD values; no illegal state is reachable from reset.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- With the macro:
  - lap in RUN captures the current count into a hold register and sets hold=1.
  - While hold=1, digits shows the held value; the internal count continues and tick/rollover still pulse.
  - A second lap releases the hold; digits shows live time on the next cycle.
  - clear or reset releases the hold.
  - lap in IDLE or PAUSE is ignored.
- Without the macro: lap is unused; digits always shows live time.

Decomposition:
- stopwatch_pkg:
  - state enum typedef (IDLE, RUN, PAUSE).
  - BCD nibble typedef.
  - DP_SEL constant.
  - digit maximum constants (9, 9, 9, 5).
- Sub-module bcd_digit_counter:
  - parameter MAX.
  - inputs: clk, rst_n, clr, inc.
  - outputs: q[3:0], carry (carry = inc && q==MAX).
  - instantiated four times, chained through carry.

Test Plan (CLK_HZ=1000, TICK_HZ=100, so DIV=10):
- Reset then start_stop at cycle 5 -> running=1; first tick 10 cycles later; digits=16'h0001; after 100 ticks digits=16'h0100.
- Preload to 59.98 via ticks, run 2 ticks -> digits 16'h5999, then 16'h0000 with rollover=1 for exactly one cycle; running stays 1.
- Pause after prescaler=4, wait 50 cycles, resume -> next tick arrives 6 cycles after resume; digits unchanged during pause.
- Clear asserted on a terminal-count cycle while in RUN -> no tick, digits=0, prescaler=0, running=1.
- rst_n=0 for one cycle mid-run at 12.34 -> next cycle digits=0, running=0, state IDLE; start_stop restarts from 00.00.
- STOPWATCH_LAP_HOLD_EN: lap at 03.21 -> digits frozen at 16'h0321 for 200 cycles while ticks continue; second lap -> digits=16'h0341.
